request_encoder: RTL
====================

# request_encoder

Registered 8-to-3 active-low priority encoder with a valid/ack handshake; it is the inverse of the team's 3-to-8 active-low line decoder. It captures falling edges on eight active-low request lines into a sticky pending set, presents the highest-priority pending request as a 3-bit code `{C,B,A}`, and holds that code until the consumer acknowledges it. A decoder output fed straight into this block returns the code that produced it.

## Interface
- `NREQ`, 8: number of request lines; fixed at 8, not for override.
- `CW`, 3: code width; fixed at 3.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `G`  in  1  active-low enable. 0 = capture and present. 1 = freeze new capture.
- `req_n`  in  8  active-low request lines. Line `7-k` low means code `k`, matching the decoder mapping.
- `ack`  in  1  consumer acknowledge; it counts only in a cycle where `valid`=1.
- `C`, `B`, `A`  out  1 each  registered code MSB..LSB.
- `valid`  out  1  code is presented and stable.
- `GS`  out  1  active-low group select; 0 whenever `pending` is non-zero.
- `pending`  out  8  sticky pending set, indexed like `req_n`.
- `ovf`  out  1  sticky overrun flag.

## Operation
- **Edge capture**
  - `prev_n` registers `req_n`; `edge = prev_n & ~req_n`.
  - When `G`=0: `pending <= (pending | edge) & ~clr`.
  - When `G`=1: `pending <= pending & ~clr`, so edges are dropped while disabled.
  - `prev_n` tracks `req_n` regardless of `G`.
- **Priority:** the lowest code wins, i.e. the highest `pending` index. Code `k` = `7 - (index of highest set pending bit)`.
- **FSM states:** IDLE, PRESENT.
  - IDLE, `G`=0 and `pending`≠0: register the priority code into `{C,B,A}`, set `valid`=1, go to PRESENT.
  - IDLE otherwise: stay in IDLE.
  - PRESENT, `ack`=0: hold `{C,B,A}` and `valid`. Presentation is never retracted, even if `G` rises.
  - PRESENT, `ack`=1: `clr` = one-hot of the presented line; `valid`=0; go to IDLE. `{C,B,A}` keeps its last value.
- **Simultaneous events**
  - A new edge on the line being cleared in the same cycle: the edge wins, and the bit stays set.
  - An edge on an already-pending bit that is not being cleared sets `ovf`=1.
  - `ovf` is cleared only by reset.
  - Edges on other lines during PRESENT accumulate into `pending` normally.
- **Outputs**
  - `GS` is combinational from `pending`: `GS = ~|pending`.
  - All other outputs are registered.
- **Reset (`rst_n`=0, immediate)**
  - State IDLE.
  - `pending`=0, `prev_n`=8'hFF, `{C,B,A}`=3'b000, `valid`=0, `ovf`=0, `GS`=1.
  - Reset mid-PRESENT discards the presentation and all pending requests.

## Timing
- A `req_n` bit is low at edge k and was high at edge k-1 → `pending` bit is set after edge k.
- `valid` with its code follows after edge k+1: 2-cycle latency from the request edge.
- `ack` sampled at edge m → `valid`=0 and the bit cleared after m.
- The next presentation is valid no earlier than after edge m+1, giving a mandatory one-cycle bubble. Maximum throughput is one code per 2 cycles.
- `ack` while `valid`=0 is ignored.
- A request held low for many cycles is captured once. It must return high before it can be captured again.

## Structure
- Shared package `encoder_pkg`:
  - `NREQ`, `CW`.
  - State encoding constants `ST_IDLE`=0, `ST_PRESENT`=1.
  - Function or constant for the line↔code mapping (`7-k`), shared with the decoder bench.
- One combinational sub-module `prio_enc8`:
  - Inputs: `pending[7:0]`.
  - Outputs: `code[2:0]` and `any`.
  - Used in IDLE for code selection and for `GS`.
- Top level holds the edge detector, `pending`/`ovf` registers, FSM and output registers.

## Test plan
1. **Reset and single request.**
   - Stimulus: drop `rst_n` mid-run; all `req_n`=8'hFF, `G`=0; then `req_n`→8'hDF.
   - Required: all reset values hold after reset. `pending`=8'h20 after 1 edge; `valid`=1 with `{C,B,A}`=010 after 2 edges; `GS`=0.
2. **Priority and bubble.**
   - Stimulus: falling edges on bits 2 and 6 in the same cycle.
   - Required: code 001 presented first. `ack` → `valid` low for exactly 1 cycle, then code 101. After the second `ack`, `pending`=0 and `GS`=1.
3. **Enable gating.**
   - Stimulus: `G`=1 while bit 0 falls.
   - Required: `pending` unchanged and `valid` stays 0.
   - Stimulus: `G`=1 raised during PRESENT.
   - Required: code held until `ack`.
4. **Collision.**
   - Stimulus: `ack` of code 000 in the same cycle bit 7 has a new falling edge.
   - Required: bit 7 stays pending, code 000 is re-presented after the bubble, and `ovf` stays 0.
   - Stimulus: a repeat edge on a pending, unpresented bit.
   - Required: `ovf`=1 and sticky.
5. **Round trip.**
   - Stimulus: drive each decoder output for codes 0–7 in turn into `req_n`, with an idle 8'hFF between codes.
   - Required: the presented `{C,B,A}` equals the decoder's input code for all 8 codes.
6. **Reset mid-operation.**
   - Stimulus: assert `rst_n`=0 while PRESENT with 3 bits pending.
   - Required: outputs reach reset values immediately, with no presentation after release until new edges arrive.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the request encoder and the matching line decoder:
// sizes, FSM state encoding and the line <-> code mapping.
package encoder_pkg;

    localparam int NREQ = 8;
    localparam int CW   = 3;

    // Highest code value; line index and code are mirror images of each other.
    localparam logic [CW-1:0] MAX_CODE = CW'(NREQ - 1);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Line index (0..7) of req_n/pending to the code it represents.
    function automatic logic [CW-1:0] line_to_code(input logic [CW-1:0] line);
        return MAX_CODE - line;
    endfunction

    // Code back to the line index it occupies on req_n/pending.
    function automatic logic [CW-1:0] code_to_line(input logic [CW-1:0] code);
        return MAX_CODE - code;
    endfunction

    // One-hot mask of the line that carries a given code.
    function automatic logic [NREQ-1:0] code_onehot(input logic [CW-1:0] code);
        logic [NREQ-1:0] one;
        one = {{(NREQ-1){1'b0}}, 1'b1};
        return one << code_to_line(code);
    endfunction

endpackage

// File: rtl/prio_enc8.sv
// Combinational priority encoder over the pending set. The highest set index
// wins, which is the lowest code.
module prio_enc8
    import encoder_pkg::*;
(
    input  logic [NREQ-1:0] pending,
    output logic [CW-1:0]   code,
    output logic            any
);

    // Ascending scan so the last (highest) set bit overrides earlier ones.
    always_comb begin
        code = '0;
        any  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (pending[i]) begin
                code = line_to_code(CW'(i));
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Registered 8-to-3 active-low priority encoder with valid/ack handshake.
// Falling edges on req_n are latched into a sticky pending set; the highest
// priority pending request is presented as {C,B,A} until acknowledged.
module request_encoder
    import encoder_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            G,
    input  logic [NREQ-1:0] req_n,
    input  logic            ack,
    output logic            C,
    output logic            B,
    output logic            A,
    output logic            valid,
    output logic            GS,
    output logic [NREQ-1:0] pending,
    output logic            ovf
);

    state_t          state;
    logic [NREQ-1:0] prev_n;
    logic [CW-1:0]   code_reg;

    logic [NREQ-1:0] edge_det;
    logic [NREQ-1:0] capt;
    logic [NREQ-1:0] clr;
    logic [NREQ-1:0] pending_next;
    logic            ovf_set;
    logic [CW-1:0]   prio_code;
    logic            prio_any;

    prio_enc8 u_prio (
        .pending (pending),
        .code    (prio_code),
        .any     (prio_any)
    );

    // Edge detection, clear of the acknowledged line and overrun detection.
    // A new edge on the line being cleared re-arms it (edge wins over clear).
    always_comb begin
        edge_det = prev_n & ~req_n;
        capt     = edge_det & {NREQ{~G}};
        clr      = '0;
        if (state == ST_PRESENT && ack) begin
            clr = code_onehot(code_reg);
        end
        pending_next = (pending & ~clr) | capt;
        ovf_set      = |(capt & pending & ~clr);
    end

    // Edge history, pending set and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_n  <= '1;
            pending <= '0;
            ovf     <= 1'b0;
        end else begin
            prev_n  <= req_n;
            pending <= pending_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Presentation FSM: latch the priority code from IDLE, hold it until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            code_reg <= '0;
            valid    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!G && prio_any) begin
                        code_reg <= prio_code;
                        valid    <= 1'b1;
                        state    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (ack) begin
                        valid <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign {C, B, A} = code_reg;
    assign GS        = ~prio_any;

endmodule
